// File: rtl/axi_lite_prefetch_reader_pkg.sv
// Shared AXI response codes and FSM state types
// for the prefetching AXI4-Lite reader.
package axi_reader_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_prefetch_reader_fifo.sv
// Synchronous word FIFO with flush; head word is
// visible combinationally (first-word-fall-through).
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop && !i_flush && !o_empty;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_prefetch_reader.sv
// AXI4-Lite master: prefetches words into a FIFO served
// one byte lane per pop, and writes winner IDs back.
module axi_lite_prefetch_reader
  import axi_reader_pkg::*;
#(
  parameter int                 ADDR_W     = 4,
  parameter int                 DATA_W     = 32,
  parameter int                 BYTE_W     = 8,
  parameter int                 ID_W       = 5,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RD_ADDR    = 'h0,
  parameter logic [ADDR_W-1:0]  WR_ADDR    = 'h4
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  read_signal,
  output logic                  read_valid,
  output logic [BYTE_W-1:0]     out_data,
  input  logic                  infer_ready,
  input  logic [ID_W-1:0]       winner_ID,
  output logic                  wr_busy,
  output logic                  rd_err,
  output logic                  wr_err,
  output logic                  overrun
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         r_rstate;
  wr_state_t         r_wstate;
  logic              r_discard;
  logic [LW-1:0]     r_lane;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_lane_last;
  logic              w_pop_lane;
  logic              w_pop_word;
  logic              w_push;
  logic              w_issue;
  logic              w_aw_done;
  logic              w_w_done;
  logic [BYTE_W-1:0] w_lanes [LANES];

  assign read_valid  = !w_empty;
  assign wr_busy     = (r_wstate != W_IDLE);
  assign w_lane_last = (r_lane == LW'(LANES - 1));
  assign w_pop_lane  = read_signal && !w_empty && !flush;
  assign w_pop_word  = w_pop_lane && w_lane_last;
  assign w_push      = (r_rstate == R_DATA) && m_axi_rvalid
                    && (m_axi_rresp == RESP_OKAY) && !r_discard
                    && !flush && (!w_full || w_pop_word);
  // one outstanding read, so the FIFO count alone bounds the issue
  assign w_issue     = enable && !flush
                    && (int'(w_count) < FIFO_DEPTH);
  assign w_aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_w_done    = !m_axi_wvalid || m_axi_wready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = w_head[g*BYTE_W +: BYTE_W];
  end
  assign out_data = w_lanes[r_lane];

  sync_word_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (m_axi_aclk),
    .i_rst   (m_axi_areset),
    .i_push  (w_push),
    .i_din   (m_axi_rdata),
    .i_pop   (w_pop_word),
    .i_flush (flush),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset || flush) begin
      r_lane <= '0;
    end else if (w_pop_lane) begin
      r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_rstate      <= R_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      r_discard     <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: if (w_issue) begin
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= RD_ADDR;
          r_rstate      <= R_ADDR;
        end
        R_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          r_rstate      <= R_DATA;
        end
        R_DATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          r_rstate     <= R_IDLE;
          if (m_axi_rresp != RESP_OKAY) rd_err <= 1'b1;
        end
        default: r_rstate <= R_IDLE;
      endcase
      if (r_rstate == R_DATA && m_axi_rvalid)
        r_discard <= 1'b0;
      else if (flush && r_rstate != R_IDLE)
        r_discard <= 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_wstate      <= W_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      wr_err        <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (infer_ready && r_wstate != W_IDLE) overrun <= 1'b1;
      unique case (r_wstate)
        W_IDLE: if (infer_ready) begin
          m_axi_awvalid <= 1'b1;
          m_axi_awaddr  <= WR_ADDR;
          m_axi_wvalid  <= 1'b1;
          m_axi_wdata   <= DATA_W'(winner_ID);
          m_axi_wstrb   <= '1;
          r_wstate      <= W_SEND;
        end
        W_SEND: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            m_axi_bready <= 1'b1;
            r_wstate     <= W_RESP;
          end
        end
        W_RESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          r_wstate     <= W_IDLE;
          if (m_axi_bresp != RESP_OKAY) wr_err <= 1'b1;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_prefetch_reader.sv
// Bench: AXI slave model plus byte-queue reference model,
// compared against the DUT every cycle.
module tb_axi_lite_prefetch_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        enable, flush, read_signal, read_valid;
  logic [7:0]  out_data;
  logic        infer_ready, wr_busy, rd_err, wr_err, overrun;
  logic [4:0]  winner_ID;

  always #5 clk = ~clk;

  axi_lite_prefetch_reader dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_awaddr(awaddr), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_araddr(araddr), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .enable(enable), .flush(flush),
    .read_signal(read_signal), .read_valid(read_valid),
    .out_data(out_data), .infer_ready(infer_ready),
    .winner_ID(winner_ID), .wr_busy(wr_busy),
    .rd_err(rd_err), .wr_err(wr_err), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // slave configuration and state
  bit          rnd = 0;
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  int          b_dly = 0, err_pct = 0, werr_pct = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int          b_cnt = 0;
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic [31:0] dir_data[$];
  bit          aw_got = 0, w_got = 0, b_pend = 0;
  bit          hs_r = 0, hs_b = 0;

  // reference model state
  bit          chk_on = 0;
  logic [7:0]  mq[$];
  bit          inflight = 0, disc = 0, busy = 0;
  bit          e_rd_err = 0, e_wr_err = 0, e_ovr = 0;
  logic [4:0]  e_id = '0;
  int          n_ar = 0, n_aw = 0, n_b = 0, n_acc = 0, n_drop = 0;
  logic [7:0]  plog[$];
  int          pcyc[$];
  int          cyc = 0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  int          ar_len = 0, last_ar_len = 0;
  bit          prev_arv = 0, prev_arhs = 0;

  function automatic int words();
    return (mq.size() + 3) / 4;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on && !rst) begin
        chk("read_valid", 32'(read_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("wr_busy", 32'(wr_busy), 32'(busy));
        chk("rd_err", 32'(rd_err), 32'(e_rd_err));
        chk("wr_err", 32'(wr_err), 32'(e_wr_err));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        if (prev_arv && !prev_arhs)
          chk("arvalid_hold", 32'(arvalid), 32'd1);
      end
      if (rst) begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
      end else begin
        if (hs_r) begin
          rvalid = 0; r_cnt = 0;
          if (rnd) r_dly = $urandom_range(0, 4);
        end
        if (hs_b) begin
          bvalid = 0; b_cnt = 0;
          if (rnd) b_dly = $urandom_range(0, 3);
        end
        if (arvalid) begin
          arready = (ar_cnt >= ar_dly); ar_cnt++;
        end else begin
          arready = 0; ar_cnt = 0;
          if (rnd) ar_dly = $urandom_range(0, 3);
        end
        if (awvalid) begin
          awready = (aw_cnt >= aw_dly); aw_cnt++;
        end else begin
          awready = 0; aw_cnt = 0;
          if (rnd) aw_dly = $urandom_range(0, 3);
        end
        if (wvalid) begin
          wready = (w_cnt >= w_dly); w_cnt++;
        end else begin
          wready = 0; w_cnt = 0;
          if (rnd) w_dly = $urandom_range(0, 3);
        end
        if (!rvalid && rq_data.size() > 0) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1;
            rdata = rq_data.pop_front();
            rresp = rq_resp.pop_front();
          end else r_cnt++;
        end
        if (!bvalid && b_pend) begin
          if (b_cnt >= b_dly) begin
            bvalid = 1; b_pend = 0;
            bresp = ($urandom_range(0, 99) < werr_pct) ? 2'b10 : 2'b00;
          end else b_cnt++;
        end
      end
      hs_r = 0; hs_b = 0;
      if (rst) begin
        mq.delete(); rq_data.delete(); rq_resp.delete();
        plog.delete(); pcyc.delete();
        inflight = 0; disc = 0; busy = 0;
        e_rd_err = 0; e_wr_err = 0; e_ovr = 0;
        aw_got = 0; w_got = 0; b_pend = 0;
        r_cnt = 0; b_cnt = 0;
        n_ar = 0; n_aw = 0; n_b = 0; n_acc = 0; n_drop = 0;
        ar_len = 0; last_ar_len = 0;
        prev_arv = 0; prev_arhs = 0;
      end else if (chk_on) begin
        if (flush) mq.delete();
        else if (read_signal && mq.size() > 0) begin
          plog.push_back(mq[0]); pcyc.push_back(cyc);
          void'(mq.pop_front());
        end
        if (arvalid && !inflight) begin
          inflight = 1;
          chk("issue_room", 32'(words() < DEPTH), 32'd1);
        end
        if (arvalid) ar_len++;
        if (arvalid && arready) begin
          n_ar++; last_ar_len = ar_len; ar_len = 0;
          chk("araddr", 32'(araddr), 32'h0);
          rq_data.push_back(dir_data.size() > 0 ?
                            dir_data.pop_front() : $urandom);
          rq_resp.push_back(($urandom_range(0, 99) < err_pct) ?
                            2'b10 : 2'b00);
        end
        if (rvalid && rready) begin
          hs_r = 1;
          if (rresp != 2'b00) e_rd_err = 1;
          else if (disc || flush) n_drop++;
          else begin
            chk("push_room", 32'(words() < DEPTH), 32'd1);
            for (int i = 0; i < 4; i++) mq.push_back(rdata[8*i +: 8]);
          end
          inflight = 0; disc = 0;
        end else if (flush && inflight) disc = 1;
        if (infer_ready) begin
          if (busy) e_ovr = 1;
          else begin busy = 1; e_id = winner_ID; n_acc++; end
        end
        if (awvalid && awready) begin
          n_aw++; aw_got = 1;
          chk("awaddr", 32'(awaddr), 32'h4);
        end
        if (wvalid && wready) begin
          w_got = 1; last_wdata = wdata; last_wstrb = wstrb;
          chk("wdata", wdata, {27'd0, e_id});
          chk("wstrb", 32'(wstrb), 32'hF);
        end
        if (aw_got && w_got) begin
          b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
        end
        if (bvalid && bready) begin
          n_b++; hs_b = 1; busy = 0;
          if (bresp != 2'b00) e_wr_err = 1;
        end
        prev_arv = arvalid; prev_arhs = arvalid && arready;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; flush = 0; read_signal = 0;
    infer_ready = 0; winner_ID = '0;
    tick(2);
    rst = 0; chk_on = 1;
  endtask

  logic [7:0] exp_b [8];

  initial begin
    int t;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", 32'(wstrb), 0);

    // streaming two known words
    dir_data.push_back(32'h44332211); dir_data.push_back(32'h88776655);
    enable = 1; read_signal = 1;
    t = 0;
    while (plog.size() < 8 && t < 100) begin tick(1); t++; end
    chk("stream_timeout", 32'(plog.size() >= 8), 1);
    if (plog.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        chk("stream_byte", 32'(plog[i]), 32'(exp_b[i]));
        chk("stream_consec", 32'(pcyc[i]), 32'(pcyc[0] + i));
      end

    // fill without pops
    do_reset();
    enable = 1;
    tick(40);
    chk("fill_ar_count", 32'(n_ar), 4);
    chk("fill_arvalid", 32'(arvalid), 0);
    read_signal = 1; tick(4); read_signal = 0;
    tick(30);
    chk("refill_ar_count", 32'(n_ar), 5);

    // slow arready
    do_reset();
    ar_dly = 5; enable = 1;
    t = 0;
    while (n_ar < 1 && t < 50) begin tick(1); t++; end
    chk("slow_ar_len", 32'(last_ar_len), 6);
    enable = 0; tick(10); ar_dly = 0;

    // read error response
    do_reset();
    err_pct = 100; enable = 1;
    tick(12);
    chk("slverr_rd_err", 32'(rd_err), 1);
    chk("slverr_rvalid", 32'(read_valid), 0);
    enable = 0; tick(8); err_pct = 0;

    // write with late wready, plus overrun
    do_reset();
    w_dly = 2;
    winner_ID = 5'd17; infer_ready = 1; tick(1);
    winner_ID = 5'd3; tick(1);
    infer_ready = 0;
    t = 0;
    while (n_b < 1 && t < 50) begin tick(1); t++; end
    tick(2);
    chk("wr_wdata", last_wdata, 32'h11);
    chk("wr_wstrb", 32'(last_wstrb), 32'hF);
    chk("wr_b_count", 32'(n_b), 1);
    chk("wr_aw_count", 32'(n_aw), 1);
    chk("wr_busy_done", 32'(wr_busy), 0);
    chk("wr_overrun", 32'(overrun), 1);
    w_dly = 0;

    // flush during R_DATA with two words held
    do_reset();
    enable = 1;
    t = 0;
    while (words() < 2 && t < 50) begin tick(1); t++; end
    r_dly = 10;
    t = 0;
    while (!rready && t < 50) begin tick(1); t++; end
    chk("fl_rready", 32'(rready), 1);
    chk("fl_words", 32'(words()), 2);
    dir_data.push_back(32'hA1B2C3D4);
    flush = 1; tick(1); flush = 0;
    chk("fl_read_valid", 32'(read_valid), 0);
    r_dly = 0;
    t = 0;
    while (!read_valid && t < 50) begin tick(1); t++; end
    chk("fl_drop", 32'(n_drop), 1);
    chk("fl_next_valid", 32'(read_valid), 1);
    chk("fl_next_byte", 32'(out_data), 32'hD4);
    enable = 0; tick(10);

    // reset in the middle of a write
    do_reset();
    aw_dly = 10; w_dly = 10;
    winner_ID = 5'd9; infer_ready = 1; tick(1); infer_ready = 0;
    tick(2);
    chk("mid_busy_before", 32'(wr_busy), 1);
    rst = 1; tick(1);
    chk("mid_awvalid", 32'(awvalid), 0);
    chk("mid_wvalid", 32'(wvalid), 0);
    chk("mid_wr_busy", 32'(wr_busy), 0);
    chk("mid_flags", {29'd0, rd_err, wr_err, overrun}, 0);
    rst = 0; aw_dly = 0; w_dly = 0;

    // randomized traffic
    do_reset();
    rnd = 1; err_pct = 5; werr_pct = 10;
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < 1500; i++) begin
        enable = ($urandom_range(0, 7) != 0);
        read_signal = ph == 0 ? ($urandom_range(0, 2) != 0)
                              : ($urandom_range(0, 5) == 0);
        flush = ($urandom_range(0, 39) == 0);
        infer_ready = ($urandom_range(0, 24) == 0);
        winner_ID = 5'($urandom);
        tick(1);
      end
    enable = 0; flush = 0; infer_ready = 0; read_signal = 0;
    tick(60);
    chk("rand_aw_all", 32'(n_aw), 32'(n_acc));
    chk("rand_b_all", 32'(n_b), 32'(n_acc));
    chk("rand_idle", 32'(wr_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
